xbar_arbiter: RTL and testbench

//  Shares the single crossbar slave path (pma decode + chip mux) between NUM_MASTERS bus masters
//  (e.g. ifetch, LSU, debug). Round-robin arbitrates the A channel; one transaction in flight.

---
 rtl/xbar_arbiter.sv | 164 ++++++++++++++++
 tb/tb_xbar_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_arbiter.sv
// Round-robin arbiter sharing one crossbar slave path between bus masters.
// One transaction in flight; decode errors and timeouts answered locally.
module xbar_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT     = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_MASTERS-1:0]          m_a_valid,
  output logic [NUM_MASTERS-1:0]          m_a_ready,
  input  logic [NUM_MASTERS-1:0]          m_a_write,
  input  logic [NUM_MASTERS*64-1:0]       m_a_address,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_a_data,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_a_mask,
  output logic [NUM_MASTERS-1:0]          m_d_valid,
  input  logic [NUM_MASTERS-1:0]          m_d_ready,
  output logic [DATA_W-1:0]               m_d_data,
  output logic                            m_d_error,
  output logic                            s_a_valid,
  input  logic                            s_a_ready,
  output logic                            s_a_write,
  output logic [63:0]                     s_a_address,
  output logic [DATA_W-1:0]               s_a_data,
  output logic [DATA_W/8-1:0]             s_a_mask,
  input  logic [5:0]                      pma_chip_sel,
  input  logic                            s_d_valid,
  output logic                            s_d_ready,
  input  logic [DATA_W-1:0]               s_d_data,
  input  logic                            s_d_error
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int MW = DATA_W / 8;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_MASTERS - 1);

  typedef enum logic [2:0] {
    IDLE, DECODE, REQ, WAIT, RESP
  } state_t;

  state_t state, state_nx;
  logic [GW-1:0] last_grant, grant, win;
  logic [7:0] cnt;
  logic any_valid, expired, accept;
  logic resp_load, resp_err;
  logic [DATA_W-1:0] resp_data;

  // nearest valid master after last_grant wins; scan far-to-near
  always_comb begin
    win = last_grant;
    any_valid = 1'b0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      int s;
      s = int'(last_grant) + k;
      if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
      if (m_a_valid[GW'(s)]) begin
        win = GW'(s);
        any_valid = 1'b1;
      end
    end
  end

  assign expired = (cnt >= TO_LAST);

  always_comb begin
    state_nx  = state;
    m_a_ready = '0;
    m_d_valid = '0;
    s_a_valid = 1'b0;
    s_d_ready = 1'b0;
    accept    = 1'b0;
    resp_load = 1'b0;
    resp_err  = 1'b1;
    resp_data = '0;
    unique case (state)
      IDLE: begin
        s_d_ready = 1'b1;
        if (any_valid) begin
          m_a_ready[win] = 1'b1;
          accept = 1'b1;
          state_nx = DECODE;
        end
      end
      DECODE: begin
        s_d_ready = 1'b1;
        if (pma_chip_sel == 6'd0) begin
          resp_load = 1'b1;
          state_nx = RESP;
        end else begin
          state_nx = REQ;
        end
      end
      REQ: begin
        s_a_valid = 1'b1;
        s_d_ready = 1'b1;
        if (s_a_ready) begin
          state_nx = WAIT;
        end else if (expired) begin
          resp_load = 1'b1;
          state_nx = RESP;
        end
      end
      WAIT: begin
        s_d_ready = 1'b1;
        if (s_d_valid) begin
          resp_load = 1'b1;
          resp_err  = s_d_error;
          resp_data = s_d_data;
          state_nx  = RESP;
        end else if (expired) begin
          resp_load = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        m_d_valid[grant] = 1'b1;
        if (m_d_ready[grant]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // outputs fall to their reset values while reset is held
    if (reset) begin
      m_a_ready = '0;
      s_d_ready = 1'b0;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= LAST_INIT;
      grant       <= '0;
      cnt         <= '0;
      s_a_write   <= 1'b0;
      s_a_address <= '0;
      s_a_data    <= '0;
      s_a_mask    <= '0;
      m_d_data    <= '0;
      m_d_error   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        grant       <= win;
        s_a_write   <= m_a_write[win];
        s_a_address <= m_a_address[int'(win)*64 +: 64];
        s_a_data    <= m_a_data[int'(win)*DATA_W +: DATA_W];
        s_a_mask    <= m_a_mask[int'(win)*MW +: MW];
      end
      if (state == DECODE) begin
        cnt <= '0;
      end else if ((state == REQ || state == WAIT) && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      if (resp_load) begin
        m_d_data  <= resp_data;
        m_d_error <= resp_err;
      end
      if (state == RESP && m_d_ready[grant]) last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_xbar_arbiter.sv
// Bench for xbar_arbiter: vector table, corner sequences,
// and random traffic against a transaction-level reference.
module tb_xbar_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      m_a_valid, m_a_ready, m_a_write;
  logic [N*64-1:0]   m_a_address;
  logic [N*DW-1:0]   m_a_data;
  logic [N*DW/8-1:0] m_a_mask;
  logic [N-1:0]      m_d_valid, m_d_ready;
  logic [DW-1:0]     m_d_data;
  logic              m_d_error;
  logic              s_a_valid, s_a_ready, s_a_write;
  logic [63:0]       s_a_address;
  logic [DW-1:0]     s_a_data;
  logic [DW/8-1:0]   s_a_mask;
  logic [5:0]        pma_chip_sel;
  logic              s_d_valid, s_d_ready, s_d_error;
  logic [DW-1:0]     s_d_data;

  xbar_arbiter #(.NUM_MASTERS(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
    .m_a_write(m_a_write), .m_a_address(m_a_address),
    .m_a_data(m_a_data), .m_a_mask(m_a_mask),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
    .m_d_data(m_d_data), .m_d_error(m_d_error),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
    .s_a_write(s_a_write), .s_a_address(s_a_address),
    .s_a_data(s_a_data), .s_a_mask(s_a_mask),
    .pma_chip_sel(pma_chip_sel),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
    .s_d_data(s_d_data), .s_d_error(s_d_error)
  );

  // pma: region 0x2xxxxxxx unmapped, everything else maps somewhere
  function automatic logic [5:0] sel_fn(input logic [63:0] a);
    if (a[31:28] == 4'h2) return 6'd0;
    return {2'b00, a[31:28]} + 6'd1;
  endfunction
  always_comb pma_chip_sel = sel_fn(s_a_address);

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] oh(input int i);
    return 64'(1) << i;
  endfunction

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_a_valid = '0; m_a_write = '0; m_a_address = '0;
    m_a_data = '0; m_a_mask = '0; m_d_ready = '1;
    s_a_ready = 1'b0; s_d_valid = 1'b0;
    s_d_data = '0; s_d_error = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    settle();
    chk("rst_m_a_ready", 64'(m_a_ready), 64'(0));
    chk("rst_m_d_valid", 64'(m_d_valid), 64'(0));
    chk("rst_s_a_valid", 64'(s_a_valid), 64'(0));
    chk("rst_s_d_ready", 64'(s_d_ready), 64'(0));
    chk("rst_m_d_data", m_d_data, 64'(0));
    chk("rst_m_d_error", 64'(m_d_error), 64'(0));
    chk("rst_s_a_address", s_a_address, 64'(0));
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int m, input logic wr,
                         input logic [63:0] a, input logic [63:0] d);
    m_a_valid[m] = 1'b1;
    m_a_write[m] = wr;
    m_a_address[m*64 +: 64] = a;
    m_a_data[m*DW +: DW] = d;
    m_a_mask[m*(DW/8) +: DW/8] = '1;
  endtask

  // called in the grant cycle; runs to the response and its accept
  task automatic serve(input int dly, input logic [63:0] sdata,
                       input logic serr, input int maxk,
                       input logic [N-1:0] clr,
                       output int lat, output int sa_first,
                       output logic [63:0] sa_addr, output logic sa_wr,
                       output logic [N-1:0] dv, output logic [63:0] dd,
                       output logic de);
    int hs;
    hs = -1; lat = -1; sa_first = -1;
    sa_addr = '0; sa_wr = 1'b0; dv = '0; dd = '0; de = 1'b0;
    s_a_ready = 1'b1;
    tick();
    m_a_valid = m_a_valid & ~clr;
    for (int k = 1; k <= maxk; k++) begin
      s_d_valid = (hs >= 0 && k == hs + 1 + dly);
      s_d_data = sdata;
      s_d_error = serr;
      settle();
      if (s_a_valid && sa_first < 0) begin
        sa_first = k; sa_addr = s_a_address; sa_wr = s_a_write;
      end
      if (s_a_valid && s_a_ready && hs < 0) hs = k;
      if (m_d_valid != '0) begin
        lat = k; dv = m_d_valid; dd = m_d_data; de = m_d_error;
        break;
      end
      tick();
    end
    s_d_valid = 1'b0;
    s_a_ready = 1'b0;
    tick();
  endtask

  typedef struct {
    int          m;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] sdata;
    logic        serr;
    int          dly;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_sa;
  } vec_t;

  vec_t tbl[5];
  int lat, saf, w, done, ref_last, slv_dly, exp_m;
  logic [63:0] saa, dd, exp_addr, exp_d, slv_d;
  logic saw, de, exp_e, exp_wr, exp_busy, slv_have, inv_ok;
  logic [N-1:0] dv, pend;

  function automatic int model_winner(input logic [N-1:0] v,
                                      input int last);
    for (int d = 1; d <= N; d++)
      if (v[(last + d) % N]) return (last + d) % N;
    return -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 1'b0, 64'h80000000, 64'h0, 64'hDEADBEEF, 1'b0, 1,
               64'hDEADBEEF, 1'b0, 5, 2};
    tbl[1] = '{1, 1'b1, 64'h20000000, 64'h1111, 64'hFFFF, 1'b0, 0,
               64'h0, 1'b1, 2, -1};
    tbl[2] = '{0, 1'b0, 64'h40000000, 64'h0, 64'h1234, 1'b1, 0,
               64'h1234, 1'b1, 4, 2};
    tbl[3] = '{1, 1'b1, 64'h10000000, 64'hCAFE, 64'h0, 1'b0, 2,
               64'h0, 1'b0, 6, 2};
    tbl[4] = '{1, 1'b0, 64'h80000008, 64'h0, 64'h0123456789ABCDEF,
               1'b0, 3, 64'h0123456789ABCDEF, 1'b0, 7, 2};

    do_reset();

    // vector table: single-master transactions
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      set_req(tbl[i].m, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      settle();
      chk("tbl_grant", 64'(m_a_ready), oh(tbl[i].m));
      serve(tbl[i].dly, tbl[i].sdata, tbl[i].serr, 20,
            N'(oh(tbl[i].m)), lat, saf, saa, saw, dv, dd, de);
      chk("tbl_latency", 64'(lat), 64'(tbl[i].exp_lat));
      chk("tbl_s_a_first", 64'(saf), 64'(tbl[i].exp_sa));
      chk("tbl_d_route", 64'(dv), oh(tbl[i].m));
      chk("tbl_d_data", dd, tbl[i].exp_data);
      chk("tbl_d_error", 64'(de), 64'(tbl[i].exp_err));
      if (tbl[i].exp_sa >= 0) begin
        chk("tbl_s_a_address", saa, tbl[i].addr);
        chk("tbl_s_a_write", 64'(saw), 64'(tbl[i].wr));
      end
      settle();
      chk("tbl_d_cleared", 64'(m_d_valid), 64'(0));
    end

    // round robin with both masters always requesting
    do_reset();
    set_req(0, 1'b0, 64'h80000000, 64'h0);
    set_req(1, 1'b0, 64'h80000010, 64'h0);
    for (int j = 0; j < 4; j++) begin
      w = 0;
      settle();
      while (m_a_ready == '0 && w < 20) begin
        tick(); settle(); w++;
      end
      chk("arb_grant", 64'(m_a_ready), oh(j % 2));
      serve(0, 64'(j), 1'b0, 20, '0, lat, saf, saa, saw, dv, dd, de);
      chk("arb_route", 64'(dv), oh(j % 2));
      chk("arb_data", dd, 64'(j));
    end
    idle_inputs();

    // response stalled by the master for 10 cycles
    m_d_ready = '0;
    set_req(0, 1'b0, 64'h80000000, 64'h0);
    settle();
    chk("stall_grant", 64'(m_a_ready), oh(0));
    serve(0, 64'hA5A5, 1'b0, 20, N'(1), lat, saf, saa, saw, dv, dd, de);
    chk("stall_first", 64'(dv), oh(0));
    set_req(1, 1'b0, 64'h80000010, 64'h0);
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("stall_valid", 64'(m_d_valid), oh(0));
      chk("stall_data", m_d_data, 64'hA5A5);
      chk("stall_error", 64'(m_d_error), 64'(0));
      chk("stall_no_grant", 64'(m_a_ready), 64'(0));
      tick();
    end
    m_d_ready = '1;
    settle();
    tick();
    settle();
    chk("stall_next_grant", 64'(m_a_ready), oh(1));
    serve(0, 64'h77, 1'b0, 20, N'(2), lat, saf, saa, saw, dv, dd, de);
    chk("stall_next_data", dd, 64'h77);

    // slave accepts but never answers
    idle_inputs();
    set_req(0, 1'b0, 64'h10000000, 64'h0);
    settle();
    chk("to_grant", 64'(m_a_ready), oh(0));
    serve(1000, 64'h99, 1'b0, 300, N'(1), lat, saf, saa, saw, dv, dd, de);
    chk("to_latency", 64'(lat), 64'(2 + TO));
    chk("to_error", 64'(de), 64'(1));
    chk("to_data", dd, 64'(0));
    s_d_valid = 1'b1;
    s_d_data = 64'hBAD;
    settle();
    chk("late_s_d_ready", 64'(s_d_ready), 64'(1));
    tick();
    s_d_valid = 1'b0;
    settle();
    chk("late_dropped", 64'(m_d_valid), 64'(0));
    set_req(1, 1'b0, 64'h80000020, 64'h0);
    settle();
    chk("after_to_grant", 64'(m_a_ready), oh(1));
    serve(0, 64'h5555, 1'b0, 20, N'(2), lat, saf, saa, saw, dv, dd, de);
    chk("after_to_latency", 64'(lat), 64'(4));
    chk("after_to_data", dd, 64'h5555);
    chk("after_to_error", 64'(de), 64'(0));

    // reset while waiting for the slave
    idle_inputs();
    set_req(0, 1'b0, 64'h80000040, 64'h0);
    settle();
    chk("rw_grant", 64'(m_a_ready), oh(0));
    s_a_ready = 1'b1;
    tick();
    m_a_valid = '0;
    tick();
    settle();
    chk("rw_req", 64'(s_a_valid), 64'(1));
    tick();
    settle();
    chk("rw_wait_s_a", 64'(s_a_valid), 64'(0));
    chk("rw_wait_s_d_ready", 64'(s_d_ready), 64'(1));
    do_reset();
    set_req(0, 1'b0, 64'h80000050, 64'h0);
    settle();
    chk("rw_fresh_grant", 64'(m_a_ready), oh(0));
    serve(0, 64'h600D, 1'b0, 20, N'(1), lat, saf, saa, saw, dv, dd, de);
    chk("rw_fresh_latency", 64'(lat), 64'(4));
    chk("rw_fresh_data", dd, 64'h600D);

    // random traffic against the transaction reference
    do_reset();
    ref_last = N - 1;
    pend = '0; exp_busy = 1'b0; slv_have = 1'b0; done = 0;
    exp_m = 0; exp_addr = '0; exp_d = '0; exp_e = 1'b0;
    exp_wr = 1'b0; slv_dly = 0; slv_d = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom % 3 == 0) begin
          logic [3:0] nib;
          case ($urandom % 4)
            0: nib = 4'h8;
            1: nib = 4'h2;
            2: nib = 4'h1;
            default: nib = 4'h4;
          endcase
          pend[i] = 1'b1;
          m_a_address[i*64 +: 64] = {32'h0, nib, 28'($urandom)};
          m_a_write[i] = 1'($urandom);
          m_a_data[i*DW +: DW] = {$urandom, $urandom};
        end else if (pend[i] && $urandom % 16 == 0) begin
          pend[i] = 1'b0;
        end
      end
      m_a_valid = pend;
      m_d_ready = N'($urandom);
      s_a_ready = 1'($urandom);
      s_d_valid = slv_have && slv_dly == 0;
      s_d_data = slv_d;
      s_d_error = exp_e;
      s_d_error = slv_have ? 1'($urandom % 8 == 0) : 1'b0;
      settle();
      inv_ok = $onehot0(m_a_ready) && $onehot0(m_d_valid) &&
               !(|m_a_ready && |m_d_valid);
      chk("rand_invariant", 64'(inv_ok), 64'(1));
      if (|m_a_ready) begin
        w = model_winner(pend, ref_last);
        chk("rand_grant", 64'(m_a_ready), oh(w));
        chk("rand_grant_idle", 64'(exp_busy), 64'(0));
        if (w < 0) w = 0;
        exp_busy = 1'b1;
        exp_m = w;
        exp_addr = m_a_address[w*64 +: 64];
        exp_wr = m_a_write[w];
        pend[w] = 1'b0;
        if (sel_fn(exp_addr) == 6'd0) begin
          exp_d = '0; exp_e = 1'b1;
        end
      end
      if (s_a_valid && s_a_ready) begin
        chk("rand_s_a_mapped", 64'(sel_fn(exp_addr) != 6'd0), 64'(1));
        chk("rand_s_a_address", s_a_address, exp_addr);
        chk("rand_s_a_write", 64'(s_a_write), 64'(exp_wr));
        slv_have = 1'b1;
        slv_dly = int'($urandom % 4);
        slv_d = {$urandom, $urandom};
      end else if (s_d_valid && s_d_ready) begin
        slv_have = 1'b0;
        exp_d = s_d_data;
        exp_e = s_d_error;
      end else if (slv_have && slv_dly > 0) begin
        slv_dly--;
      end
      if (|m_d_valid) begin
        chk("rand_d_route", 64'(m_d_valid), oh(exp_m));
        if (m_d_ready[exp_m]) begin
          chk("rand_d_data", m_d_data, exp_d);
          chk("rand_d_error", 64'(m_d_error), 64'(exp_e));
          ref_last = exp_m;
          exp_busy = 1'b0;
          done++;
        end
      end
      tick();
    end
    chk("rand_progress", 64'(done > 150), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
